// File: rtl/ram_arb2_pkg.sv
// Shared types and constants for the two-client RAM scheduler.
package ram_arb2_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10
  } state_t;

  localparam logic C0 = 1'b0;
  localparam logic C1 = 1'b1;

endpackage

// File: rtl/ram_arb2_rr_pick2.sv
// Two-way round-robin picker: on a tie the client that was not served last wins.
module rr_pick2
  import ram_arb2_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  // Pick a winner among the active requesters
  always_comb begin
    valid  = req0 | req1;
    winner = C0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = C1;
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// Serialises two clients onto a dual-port register-file RAM, one access per
// three cycles (IDLE -> GRANT -> WAIT), and returns read data to its issuer.
module ram_arb2
  import ram_arb2_pkg::*;
#(
  parameter int unsigned wi  = DATA_W,
  parameter int unsigned add = ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic [add-1:0] addr0,
  input  logic [add-1:0] addr1,
  input  logic [wi-1:0]  wdata0,
  input  logic [wi-1:0]  wdata1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rvalid0,
  output logic           rvalid1,
  output logic [wi-1:0]  rdata0,
  output logic [wi-1:0]  rdata1,
  output logic           ram_wr,
  output logic           ram_rd,
  output logic [add-1:0] ram_wa,
  output logic [add-1:0] ram_ra,
  output logic [wi-1:0]  ram_din,
  input  logic [wi-1:0]  ram_dout
);

  state_t         state, state_nx;
  logic           last, last_nx;
  logic           owner, owner_nx;
  logic           op_rd, op_rd_nx;
  logic           gnt0_nx, gnt1_nx;
  logic           ram_wr_nx, ram_rd_nx;
  logic [add-1:0] addr_nx;
  logic [wi-1:0]  din_nx;

  logic           pick_valid, pick_winner;
  logic           sel_we;
  logic [add-1:0] sel_addr;
  logic [wi-1:0]  sel_wdata;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Route the winning client's command fields
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (pick_winner == C1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Next state and next values of the registered RAM-side outputs
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    owner_nx  = owner;
    op_rd_nx  = op_rd;
    gnt0_nx   = 1'b0;
    gnt1_nx   = 1'b0;
    ram_wr_nx = 1'b0;
    ram_rd_nx = 1'b0;
    addr_nx   = ram_wa;
    din_nx    = ram_din;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx  = GRANT;
          last_nx   = pick_winner;
          owner_nx  = pick_winner;
          op_rd_nx  = ~sel_we;
          gnt0_nx   = (pick_winner == C0);
          gnt1_nx   = (pick_winner == C1);
          ram_wr_nx = sel_we;
          ram_rd_nx = ~sel_we;
          addr_nx   = sel_addr;
          din_nx    = sel_wdata;
        end
      end
      GRANT:   state_nx = WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= C1;
      owner   <= C0;
      op_rd   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      ram_wr  <= 1'b0;
      ram_rd  <= 1'b0;
      ram_wa  <= '0;
      ram_ra  <= '0;
      ram_din <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      owner   <= owner_nx;
      op_rd   <= op_rd_nx;
      gnt0    <= gnt0_nx;
      gnt1    <= gnt1_nx;
      ram_wr  <= ram_wr_nx;
      ram_rd  <= ram_rd_nx;
      ram_wa  <= addr_nx;
      ram_ra  <= addr_nx;
      ram_din <= din_nx;
    end
  end

  // Read data is qualified only in WAIT of a read, for the owning client
  assign rvalid0 = (state == WAIT) && op_rd && (owner == C0);
  assign rvalid1 = (state == WAIT) && op_rd && (owner == C1);
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;

endmodule

// File: tb/tb_ram_arb2.sv
// Scoreboard bench for ram_arb2 with a behavioural RAM and transaction model.
`timescale 1ns/1ps
module tb_ram_arb2;

  localparam int unsigned WI = 8;
  localparam int unsigned AD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, req1, we0, we1;
  logic [AD-1:0] addr0, addr1;
  logic [WI-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [WI-1:0] rdata0, rdata1;
  logic          ram_wr, ram_rd;
  logic [AD-1:0] ram_wa, ram_ra;
  logic [WI-1:0] ram_din, ram_dout;

  ram_arb2 #(.wi(WI), .add(AD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_wa(ram_wa), .ram_ra(ram_ra),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Register-file RAM: reset-cleared array, registered read data
  logic [WI-1:0] ram_mem [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_wr) ram_mem[ram_wa] <= ram_din;
      if (ram_rd) ram_dout <= ram_mem[ram_ra];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic cl; logic we; logic [AD-1:0] a; logic [WI-1:0] d; } gexp_t;
  typedef struct { int cyc; logic cl; logic [WI-1:0] d; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  // Reference model state: memory contents, round-robin memory, busy slots
  logic [WI-1:0] mem [16];
  logic          m_last = 1'b1;
  int            m_busy = 0;
  int            mode   = 0;
  logic          pend [2];
  logic          p_we [2];
  logic [AD-1:0] p_a  [2];
  logic [WI-1:0] p_d  [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input logic [31:0] act, input logic [31:0] req, input string nm);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
  endtask

  task automatic chk_quiet(input string nm);
    check(32'({gnt1, gnt0, ram_wr, ram_rd, ram_wa, ram_ra, ram_din, rvalid1, rvalid0}), 32'd0, nm);
  endtask

  task automatic set_req(input int c, input logic we, input logic [AD-1:0] a, input logic [WI-1:0] d);
    pend[c] = 1'b1; p_we[c] = we; p_a[c] = a; p_d[c] = d;
  endtask

  task automatic drive();
    req0 = pend[0]; we0 = p_we[0]; addr0 = p_a[0]; wdata0 = p_d[0];
    req1 = pend[1]; we1 = p_we[1]; addr1 = p_a[1]; wdata1 = p_d[1];
  endtask

  // One clock of stimulus plus the transaction-level scheduling model
  task automatic step();
    logic w;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!pend[c]) begin
        if (mode == 1) set_req(c, 1'b0, AD'(c + 1), 8'h00);
        else if (mode == 2 && $urandom_range(0, 2) == 0)
          set_req(c, 1'($urandom_range(0, 1)), AD'($urandom_range(0, 7)), WI'($urandom));
      end
    end
    drive();
    if (m_busy > 0) begin
      m_busy--;
    end else if (pend[0] || pend[1]) begin
      w = (pend[0] && pend[1]) ? !m_last : pend[1];
      gq.push_back('{cyc + 1, w, p_we[w], p_a[w], p_d[w]});
      if (p_we[w]) mem[p_a[w]] = p_d[w];
      else rq.push_back('{cyc + 2, w, mem[p_a[w]]});
      m_last  = w;
      pend[w] = 1'b0;
      m_busy  = 2;
    end
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    do begin
      step();
      n++;
    end while ((pend[0] || pend[1] || m_busy != 0 || gq.size() != 0 || rq.size() != 0) && n < maxc);
    if (pend[0] || pend[1] || m_busy != 0 || gq.size() != 0 || rq.size() != 0)
      check(32'd1, 32'd0, "drain timeout");
  endtask

  // Asynchronous reset mid-cycle; the model forgets everything in flight
  task automatic reset_now();
    @(negedge clk);
    rst = 1'b1;
    drive();
    gq.delete();
    rq.delete();
    m_busy = 0;
    m_last = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #1 chk_quiet("outputs at reset assertion");
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle
  initial begin : monitor
    logic [AD-1:0] h_a;
    logic [WI-1:0] h_d;
    logic          pg;
    logic [19:0]   ga, ge;
    logic [9:0]    va, ve;
    gexp_t         g;
    rexp_t         r;
    h_a = '0; h_d = '0; pg = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin h_a = '0; h_d = '0; end
      ge = {2'b00, 2'b00, h_a, h_a, h_d};
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        h_a = g.a; h_d = g.d;
        ge = {g.cl, ~g.cl, g.we, ~g.we, g.a, g.a, g.d};
      end
      ga = {gnt1, gnt0, ram_wr, ram_rd, ram_wa, ram_ra, ram_din};
      check(32'(ga), 32'(ge), "gnt/strobes/ram_addr/ram_din");
      ve = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        ve = {r.cl, ~r.cl, r.d};
      end
      va = {rvalid1, rvalid0, rvalid1 ? rdata1 : (rvalid0 ? rdata0 : 8'h00)};
      check(32'(va), 32'(ve), "rvalid/rdata");
      check(32'({rdata1, rdata0}), 32'({ram_dout, ram_dout}), "rdata follows ram_dout");
      check(32'(ram_wr & ram_rd), 32'd0, "ram_wr and ram_rd together");
      check(32'(pg & (gnt0 | gnt1)), 32'd0, "gnt on consecutive cycles");
      pg = gnt0 | gnt1;
    end
  end

  // Stimulus sequence
  initial begin
    for (int c = 0; c < 2; c++) begin
      pend[c] = 1'b0; p_we[c] = 1'b0; p_a[c] = '0; p_d[c] = '0;
    end
    for (int i = 0; i < 16; i++) mem[i] = '0;
    drive();
    repeat (3) @(negedge clk);
    chk_quiet("reset state");

    // Tie after reset: client 0 writes 3=A5 first, client 1 reads 2
    set_req(0, 1'b1, 4'd3, 8'hA5);
    set_req(1, 1'b0, 4'd2, 8'h5A);
    run_idle(20);
    set_req(0, 1'b0, 4'd3, 8'h00);
    run_idle(20);

    // Continuous reads from both clients alternate
    mode = 1;
    repeat (24) step();
    mode = 0;
    run_idle(20);

    // Same-cycle write/read of addr 7 from both sides of the pointer
    set_req(1, 1'b0, 4'd0, 8'h00);
    run_idle(20);
    set_req(1, 1'b1, 4'd7, 8'h3C);
    set_req(0, 1'b0, 4'd7, 8'h00);
    run_idle(20);
    set_req(0, 1'b0, 4'd7, 8'h00);
    run_idle(20);
    set_req(1, 1'b1, 4'd7, 8'h5A);
    set_req(0, 1'b0, 4'd7, 8'h00);
    run_idle(20);

    // Reset during the GRANT of a read: no rvalid, array cleared
    set_req(0, 1'b1, 4'd5, 8'h77);
    run_idle(20);
    set_req(0, 1'b0, 4'd5, 8'h00);
    step();
    reset_now();
    set_req(1, 1'b0, 4'd5, 8'h00);
    run_idle(20);

    // Reset during WAIT: rvalid drops at once, later read returns 0
    set_req(0, 1'b1, 4'd6, 8'h99);
    run_idle(20);
    set_req(1, 1'b0, 4'd6, 8'h00);
    step();
    step();
    reset_now();
    set_req(0, 1'b0, 4'd6, 8'h00);
    run_idle(20);

    // Randomised traffic
    mode = 2;
    repeat (1000) step();
    mode = 0;
    run_idle(40);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
# ram_arb2

Two-client round-robin scheduler for the team's dual-port register-file RAM (write port, read port, registered read data, reset-cleared array). Both RAM clocks are tied to this block's single clock. It serialises read/write requests from two clients into one RAM operation at a time, so the RAM's write and read strobes are never both asserted. It returns read data to the client that issued the read.

## Interface
- wi, 8, data width; equals the RAM data width
- add, 4, address width; equals the RAM address width
- clk  in  1  single clock; also drives the RAM wr_clk and rd_clk
- rst  in  1  asynchronous, active-high reset; shared with the RAM
- req0, req1  in  1  client request; held with we/addr/wdata stable until gnt
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  add  RAM address
- wdata0, wdata1  in  wi  write data
- gnt0, gnt1  out  1  one-cycle grant pulse, registered
- rvalid0, rvalid1  out  1  read data valid, combinational from state
- rdata0, rdata1  out  wi  read data, driven from ram_dout
- ram_wr, ram_rd  out  1  RAM write and read strobes, registered
- ram_wa, ram_ra, ram_din  out  add/add/wi  RAM address and data, registered
- ram_dout  in  wi  RAM registered read data

## Operation
- State machine has three states: IDLE, GRANT, WAIT.
- IDLE:
  - No request: stay in IDLE.
  - Request present: choose an owner, then go to GRANT.
  - On the transition edge, register the following: gnt of the owner = 1; ram_wr = we; ram_rd = ~we; ram_wa = ram_ra = addr; ram_din = wdata.
  - Latch the owner and the op type.
- GRANT: strobes are high for exactly this cycle. The RAM performs the access at the edge closing GRANT. Then go to WAIT.
- WAIT:
  - Strobes and gnt are 0. req inputs are ignored.
  - If the latched op is a read: rvalid of the owner = 1 and its rdata = ram_dout.
  - Then go to IDLE.
- Arbitration:
  - One requester: that client wins.
  - Both requesting: the client other than the `last` pointer wins.
  - `last` updates to the winner on every grant.
  - Reset value last = 1, so client 0 wins the first tie.
- Clients must deassert req (or present a new request) by the WAIT cycle. Any req seen in IDLE is a new request.
- Invariant: ram_wr & ram_rd is never 1.
- ram_wa, ram_ra and ram_din hold their last issued values outside GRANT.
- rdata0 and rdata1 both follow ram_dout at all times. Only rvalid qualifies them.

## Timing
- Reset values: state = IDLE; last = 1; gnt0 = gnt1 = ram_wr = ram_rd = 0; ram_wa = ram_ra = 0; ram_din = 0; rvalid0 = rvalid1 = 0.
- Request sampled in IDLE cycle N:
  - gnt and strobes high in cycle N+1.
  - Read data: rvalid high in cycle N+2.
  - Next grant is possible at cycle N+4 (the request is sampled in the IDLE cycle N+3).
- Throughput: one operation per 3 cycles.
- Write then read of the same address: the read returns the new data, because the write commits at the end of its GRANT cycle.
- Reset asserted during GRANT or WAIT:
  - Go to IDLE immediately; strobes, gnt and rvalid drop at once.
  - An in-flight read never produces rvalid.
  - The RAM clears its array on the same reset.
- req0 and req1 rising in the same IDLE cycle: exactly one gnt is issued. The loser stays pending and is granted in the next IDLE.

## Structure
- Package ram_arb2_pkg holds:
  - state encoding: IDLE = 2'b00, GRANT = 2'b01, WAIT = 2'b10
  - client index constants C0 = 1'b0, C1 = 1'b1
- Sub-module rr_pick2: combinational two-way round-robin picker.
  - Inputs: req0, req1, last.
  - Outputs: valid, winner.
- The top level holds the FSM, the registered RAM-side outputs and the owner/op latches.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 and state IDLE on the same cycle; rst released → first both-request tie grants client 0.
- Client 0 writes addr 3 = 8'hA5, then reads addr 3:
  - ram_wr pulses one cycle with ram_wa = 3 and ram_din = A5.
  - On the read, rvalid0 = 1 two cycles after the request with rdata0 = 8'hA5.
  - rvalid1 stays 0 throughout.
- Both clients hold continuous reads of addr 1 and addr 2 → grants alternate 0,1,0,1 every 3 cycles; each rvalid goes to the correct client.
- Client 1 writes addr 7 = 8'h3C while client 0 requests a read of addr 7 in the same cycle:
  - Round-robin order is respected.
  - If the write is granted first, the read returns 8'h3C; otherwise it returns the reset value 0.
- rst pulses during the WAIT cycle of a read → no rvalid; a subsequent read of any address returns 0.
- Randomized 1000-cycle run with assertions:
  - never ram_wr & ram_rd
  - gnt is one-hot or zero
  - gnt is always followed by a non-GRANT cycle
